uart_word_rx: RTL

//   UART receiver that assembles 1 or 4 serial bytes into a 32-bit word for the host command controller.

---
 rtl/uart_word_rx_pkg.sv | 6 +
 rtl/uart_word_rx_if.sv | 10 +
 rtl/uart_word_rx_sync.sv | 18 +
 rtl/uart_word_rx.sv | 125 ++++++++++++
 4 files changed

// File: rtl/uart_word_rx_pkg.sv
// uart_word_rx_pkg: receiver FSM states and UART word constants shared with the 32-bit transmitter
package uart_word_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
    localparam int UART_BYTES_PER_WORD = 4;
    localparam int DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_word_rx_if.sv
// uart_word_rx_if: serial input, word-size select and assembled-word outputs of the word receiver
interface uart_word_rx_if;
    logic        rx;
    logic        one_byte;
    logic [31:0] data_out;
    logic        data_end;
    logic        frame_err;
    modport master (output rx, one_byte, input data_out, data_end, frame_err);
    modport slave  (input rx, one_byte, output data_out, data_end, frame_err);
endinterface

// File: rtl/uart_word_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the rx pin, resets to the idle-high line level
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receiver assembling 1 or 4 LSB-first bytes into a little-endian 32-bit word.
// Optional inter-byte timeout when RX_TIMEOUT_EN is defined.
import uart_word_rx_pkg::*;
module uart_word_rx #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic            clk,
    input  logic            reset,
    uart_word_rx_if.slave   bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
    rx_state_t   state;
    logic        rx_s;
    logic [BW-1:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic        word_mode;
    logic [7:0]  byte_sr;
    logic [31:0] word_sr, word_nx, data_out;
    logic        data_end, frame_err;
`ifdef RX_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_BITS - 1);
    logic [GW-1:0] gap_cnt;
`endif
    uart_rx_sync u_sync (.clk(clk), .reset(reset), .d(bus.rx), .q(rx_s));
    always_comb begin
        word_nx = word_sr;
        word_nx[8*byte_idx +: 8] = byte_sr;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            word_mode <= 1'b0;
            byte_sr   <= '0;
            word_sr   <= '0;
            data_out  <= '0;
            data_end  <= 1'b0;
            frame_err <= 1'b0;
`ifdef RX_TIMEOUT_EN
            gap_cnt   <= '0;
`endif
        end else begin
            data_end  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                        if (byte_idx == 2'd0) word_mode <= bus.one_byte;
`ifdef RX_TIMEOUT_EN
                        gap_cnt  <= '0;
`endif
                    end
`ifdef RX_TIMEOUT_EN
                    // idle bit-times are only counted while a partial word is pending
                    else if (byte_idx != 2'd0) begin
                        baud_cnt <= (baud_cnt == LAST) ? '0 : baud_cnt + 1'b1;
                        if (baud_cnt == LAST) begin
                            gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
                            if (gap_cnt == GAP_LAST) begin
                                frame_err <= 1'b1;
                                byte_idx  <= '0;
                                word_sr   <= '0;
                            end
                        end
                    end
`endif
                end
                START: begin
                    baud_cnt <= baud_cnt + 1'b1;
                    if (baud_cnt == HALF) begin
                        state    <= rx_s ? IDLE : DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                    end
                end
                DATA: begin
                    baud_cnt <= baud_cnt + 1'b1;
                    if (baud_cnt == LAST) begin
                        baud_cnt <= '0;
                        byte_sr  <= {rx_s, byte_sr[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    baud_cnt <= baud_cnt + 1'b1;
                    if (baud_cnt == LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            if (word_mode || byte_idx == 2'd3) begin
                                data_out <= word_mode ? {24'h0, byte_sr} : word_nx;
                                data_end <= 1'b1;
                                byte_idx <= '0;
                                word_sr  <= '0;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                                word_sr  <= word_nx;
                            end
                        end else begin
                            state     <= WAIT_HIGH;
                            frame_err <= 1'b1;
                            byte_idx  <= '0;
                            word_sr   <= '0;
                        end
                    end
                end
                WAIT_HIGH: state <= rx_s ? IDLE : WAIT_HIGH;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.data_out  = data_out;
    assign bus.data_end  = data_end;
    assign bus.frame_err = frame_err;
endmodule
